// File: rtl/stream_key_match_pkg.sv
// lau_pkg: shared FSM state encoding for the stream key matcher
package lau_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/stream_key_match_if.sv
// stream_key_match_if: job control, data stream and result bundle
interface stream_key_match_if #(parameter int width = 8, parameter int lenw = 8);
  logic             Start;
  logic [width-1:0] Key;
  logic [lenw-1:0]  Len;
  logic             InValid;
  logic [width-1:0] InData;
  logic             InReady;
  logic             Busy;
  logic             Done;
  logic             Found;
  logic [lenw-1:0]  FirstIdx;
  logic [lenw-1:0]  MatchCnt;
  modport master (output Start, Key, Len, InValid, InData,
                  input  InReady, Busy, Done, Found, FirstIdx, MatchCnt);
  modport slave  (input  Start, Key, Len, InValid, InData,
                  output InReady, Busy, Done, Found, FirstIdx, MatchCnt);
endinterface

// File: rtl/stream_key_match_cmp.sv
// CmpEQ: full-width equality of two words
module CmpEQ #(parameter int width = 8) (
  input  logic [width-1:0] i_a,
  input  logic [width-1:0] i_b,
  output logic             o_eq
);
  assign o_eq = i_a == i_b;
endmodule

// File: rtl/stream_key_match.sv
// stream_key_match: counts stream words equal to a latched key over a fixed-length job
module stream_key_match
  import lau_pkg::*;
#(
  parameter int width = 8,
  parameter int lenw  = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  stream_key_match_if.slave bus
);
  state_t           r_state;
  logic [width-1:0] r_key;
  logic [lenw-1:0]  r_len;
  logic [lenw-1:0]  r_idx;
  logic [lenw-1:0]  r_first;
  logic [lenw-1:0]  r_cnt;
  logic             r_found;
  logic             w_eq;

  CmpEQ #(.width(width)) u_cmp (.i_a(bus.InData), .i_b(r_key), .o_eq(w_eq));

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      r_state <= IDLE;
      r_key   <= '0;
      r_len   <= '0;
      r_idx   <= '0;
      r_first <= '0;
      r_cnt   <= '0;
      r_found <= 1'b0;
    end else
      case (r_state)
        IDLE: if (bus.Start) begin
          r_key   <= bus.Key;
          r_len   <= bus.Len;
          r_idx   <= '0;
          r_first <= '0;
          r_cnt   <= '0;
          r_found <= 1'b0;
          r_state <= bus.Len != '0 ? RUN : DONE;
        end
        RUN: if (bus.InValid) begin
          r_idx <= r_idx + lenw'(1);
          if (w_eq) begin
            r_cnt <= r_cnt + lenw'(1);
            if (!r_found) begin
              r_found <= 1'b1;
              r_first <= r_idx;
            end
          end
          if (r_idx == r_len - lenw'(1)) r_state <= DONE;
        end
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase

  // handshake flags decode only from the state register, never from InValid
  assign bus.InReady  = r_state == RUN;
  assign bus.Busy     = r_state != IDLE;
  assign bus.Done     = r_state == DONE;
  assign bus.Found    = r_found;
  assign bus.FirstIdx = r_first;
  assign bus.MatchCnt = r_cnt;
endmodule

// File: tb/tb_stream_key_match.sv
// tb_stream_key_match: vector table plus scoreboard of expected job results
module tb_stream_key_match;
  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  stream_key_match_if #(.width(8), .lenw(8)) bus();
  stream_key_match #(.width(8), .lenw(8)) dut (.clk_i(clk), .rst_ni(rst_ni), .bus(bus));

  typedef struct packed {
    logic [7:0]  key;
    logic [7:0]  len;
    logic [3:0]  gap;
    logic [63:0] d;
    logic        f;
    logic [7:0]  fi;
    logic [7:0]  mc;
  } vec_t;
  typedef struct packed {
    logic       f;
    logic [7:0] fi;
    logic [7:0] mc;
  } res_t;

  res_t q[$];
  res_t m_e;
  vec_t v[6];
  int total = 0;
  int bad = 0;
  int done_seen = 0;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", n, a, e);
    end
  endtask

  always @(negedge clk)
    if (bus.Done) begin
      done_seen++;
      if (q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        m_e = q.pop_front();
        chk("found", bus.Found, m_e.f);
        chk("first_idx", bus.FirstIdx, m_e.fi);
        chk("match_cnt", bus.MatchCnt, m_e.mc);
        chk("busy_in_done", bus.Busy, 1);
      end
    end

  task automatic start(input logic [7:0] k, input logic [7:0] l);
    bus.Start = 1'b1;
    bus.Key = k;
    bus.Len = l;
    @(negedge clk);
    bus.Start = 1'b0;
  endtask

  task automatic xfer(input logic [7:0] d, input int gap);
    repeat (gap) begin
      bus.InValid = 1'b0;
      @(negedge clk);
      chk("gap_ready", bus.InReady, 1);
    end
    chk("ready", bus.InReady, 1);
    bus.InValid = 1'b1;
    bus.InData = d;
    @(negedge clk);
    bus.InValid = 1'b0;
  endtask

  task automatic finish_job;
    chk("done_latency", bus.Done, 1);
    @(negedge clk);
    chk("done_one_cycle", bus.Done, 0);
    chk("idle_not_busy", bus.Busy, 0);
  endtask

  task automatic run_vec(input vec_t x);
    q.push_back('{x.f, x.fi, x.mc});
    start(x.key, x.len);
    for (int i = 0; i < int'(x.len); i++) xfer(x.d[i*8 +: 8], int'(x.gap));
    finish_job();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int ds;
    v[0] = '{8'h5A, 8'd4, 4'd0, 64'h5A115A00, 1'b1, 8'd1, 8'd2};
    v[1] = '{8'hFF, 8'd3, 4'd2, 64'hFE0100, 1'b0, 8'd0, 8'd0};
    v[2] = '{8'h33, 8'd1, 4'd0, 64'h33, 1'b1, 8'd0, 8'd1};
    v[3] = '{8'hA5, 8'd5, 4'd1, 64'h25A5A5A5A4, 1'b1, 8'd1, 8'd3};
    v[4] = '{8'h00, 8'd8, 4'd0, 64'h0, 1'b1, 8'd0, 8'd8};
    v[5] = '{8'h7E, 8'd6, 4'd0, 64'h7E0504030201, 1'b1, 8'd5, 8'd1};
    bus.Start = 1'b0;
    bus.Key = '0;
    bus.Len = '0;
    bus.InValid = 1'b0;
    bus.InData = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", bus.InReady, 0);
    chk("rst_busy", bus.Busy, 0);
    chk("rst_done", bus.Done, 0);
    chk("rst_found", bus.Found, 0);
    chk("rst_first", bus.FirstIdx, 0);
    chk("rst_cnt", bus.MatchCnt, 0);
    rst_ni = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 6; i++) run_vec(v[i]);
    // zero-length job goes straight to DONE with cleared results
    q.push_back('{1'b0, 8'd0, 8'd0});
    start(8'h7E, 8'd0);
    chk("len0_ready", bus.InReady, 0);
    finish_job();
    // Start during RUN must not reload the key
    q.push_back('{1'b1, 8'd0, 8'd2});
    start(8'h3C, 8'd3);
    xfer(8'h3C, 0);
    bus.Start = 1'b1;
    bus.Key = 8'hC3;
    bus.Len = 8'd1;
    xfer(8'hC3, 0);
    bus.Start = 1'b0;
    chk("restart_ignored", bus.Busy, 1);
    xfer(8'h3C, 0);
    finish_job();
    q.push_back('{1'b1, 8'd0, 8'd255});
    start(8'h5A, 8'd255);
    for (int i = 0; i < 255; i++) xfer(8'h5A, 0);
    finish_job();
    // reset in the middle of a job abandons it without a Done pulse
    q.push_back('{1'b0, 8'd0, 8'd0});
    start(8'h22, 8'd4);
    xfer(8'h22, 0);
    xfer(8'h00, 0);
    ds = done_seen;
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_ready", bus.InReady, 0);
    chk("mid_rst_busy", bus.Busy, 0);
    chk("mid_rst_done", bus.Done, 0);
    chk("mid_rst_found", bus.Found, 0);
    chk("mid_rst_first", bus.FirstIdx, 0);
    chk("mid_rst_cnt", bus.MatchCnt, 0);
    q.delete();
    @(negedge clk);
    chk("no_done_on_reset", done_seen, ds);
    rst_ni = 1'b1;
    q.push_back('{1'b1, 8'd0, 8'd1});
    start(8'h11, 8'd1);
    chk("start_after_reset", bus.Busy, 1);
    xfer(8'h11, 0);
    finish_job();
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/stream_key_match.md
STREAM_KEY_MATCH -- requirements
Module: stream_key_match

Interface
REQ-001 SHALL have parameter width, default 8, meaning data and key word width in bits.
REQ-002 SHALL have parameter lenw, default 8, meaning width of the length, index and count fields.
REQ-003 SHALL have port clk_i  input  1  the single clock; all state on rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port Start  input  1  request to begin a search job; accepted only in IDLE.
REQ-006 SHALL have port Key  input  width  search key; sampled when Start is accepted.
REQ-007 SHALL have port Len  input  lenw  number of words in the job; sampled when Start is accepted.
REQ-008 SHALL have port InValid  input  1  upstream data valid.
REQ-009 SHALL have port InData  input  width  upstream data word.
REQ-010 SHALL have port InReady  output  1  block accepts InData this cycle.
REQ-011 SHALL have port Busy  output  1  high in RUN and DONE.
REQ-012 SHALL have port Done  output  1  one-cycle pulse at job completion.
REQ-013 SHALL have port Found  output  1  at least one word equalled Key in the last job.
REQ-014 SHALL have port FirstIdx  output  lenw  index (0-based) of the first matching word; 0 when Found=0.
REQ-015 SHALL have port MatchCnt  output  lenw  number of matching words in the last job.

Function
REQ-016 SHALL implement the FSM states IDLE, RUN, DONE.
REQ-017 SHALL move from IDLE to RUN on Start=1 with Len!=0, latching Key and Len and clearing Found, FirstIdx, MatchCnt and the word index.
REQ-018 SHALL move from IDLE to DONE on Start=1 with Len=0, clearing the results so that Found=0, FirstIdx=0, MatchCnt=0.
REQ-019 SHALL drive InReady=1 only in RUN; a transfer occurs when InValid=1 and InReady=1 are sampled high at the same clock edge.
REQ-020 SHALL compare each transferred InData against the latched key, using full-width equality with no masking.
REQ-021 SHALL, on a transferred match, increment MatchCnt; if Found was 0, it SHALL also set Found=1 and FirstIdx to the current index, in the same edge.
REQ-022 SHALL increment the index on every transfer and move from RUN to DONE on the transfer where the index equals latched Len-1.
REQ-023 SHALL hold all state in RUN while InValid=0; there is no timeout.
REQ-024 SHALL assert Done=1 for exactly one cycle in DONE, then return to IDLE unconditionally.
REQ-025 SHALL ignore Start in RUN and DONE; a new Start is only honoured in IDLE.
REQ-026 SHALL hold Found, FirstIdx and MatchCnt stable from DONE until the next accepted Start; the held values are valid when Done=1.
REQ-027 SHALL produce latency of 1 cycle from the last transfer to Done, and a minimum job time of Len+1 cycles after Start.
REQ-028 SHALL never let MatchCnt overflow, because MatchCnt <= Len <= 2^lenw-1; the latched Key and Len SHALL ignore Key and Len input changes during RUN.

Reset
REQ-029 SHALL, while rst_ni=0, asynchronously force state=IDLE, InReady=0, Busy=0, Done=0, Found=0, FirstIdx=0, MatchCnt=0, index=0, and the latched key and length to 0.
REQ-030 SHALL abandon a job cleanly on reset mid-RUN with no Done pulse, and SHALL accept Start at the first rising edge after rst_ni deasserts.

Structure
REQ-031 SHALL place the FSM state enum (IDLE, RUN, DONE) in the shared package lau_pkg.
REQ-032 SHALL instantiate CmpEQ (parameter width) as the sole sub-module for the key/data equality.
REQ-033 SHALL register all outputs or decode them only from registered state, with no combinational path from InValid to InReady.

Verification
REQ-034 Reset mid-job: Start, Len=4, 2 transfers, then rst_ni pulse low -> all outputs 0, no Done, state IDLE.
REQ-035 width=8, Key=0x5A, Len=4, data 0x00,0x5A,0x11,0x5A back-to-back -> Done 1 cycle after the 4th transfer, Found=1, FirstIdx=1, MatchCnt=2.
REQ-036 Key=0xFF, Len=3, data 0x00,0x01,0xFE with InValid gaps of 2 cycles -> InReady stays high during the gaps, Done after the 3rd transfer, Found=0, FirstIdx=0, MatchCnt=0.
REQ-037 Len=0 Start -> DONE next cycle, Done pulse, InReady never high, all results 0.
REQ-038 Start re-asserted during RUN with a different Key -> ignored, the original key is used; Len=255 all-match -> MatchCnt=255 with no wrap.
